// File: rtl/lsu_ctrl.sv
// Load/store control unit: byte/half/word accesses on a single-word memory port,
// sub-word stores as read-modify-write. Optional macro LSU_BOUNDS_CHECK_EN faults out-of-range addresses.
module lsu_ctrl #(
    parameter int ADDR_WORDS_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);
    localparam int AW = ADDR_WORDS_LOG2 + 2;

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

    state_t        state_q, state_d;
    logic          is_store_q, is_store_d;
    logic [1:0]    size_q, size_d;
    logic          sign_ext_q, sign_ext_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   merge_q, merge_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          misaligned;
    logic          out_of_range;
    logic          unused_addr_hi;

    // Big-endian lanes: byte offset k occupies [31-8k -: 8].
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[31 - 8*off -: 8];
        h = off[1] ? w[15:0] : w[31:16];
        if (sz[1])
            return w;
        else if (sz[0])
            return {{16{sx & h[15]}}, h};
        else
            return {{24{sx & b[7]}}, b};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        if (sz[1])
            r = d;
        else if (sz[0]) begin
            if (off[1]) r[15:0] = d[15:0];
            else        r[31:16] = d[15:0];
        end else
            r[31 - 8*off -: 8] = d[7:0];
        return r;
    endfunction

    assign misaligned = size[1] ? (addr[1:0] != 2'b00) : (size[0] & addr[0]);
    assign unused_addr_hi = ^addr[31:AW];
`ifdef LSU_BOUNDS_CHECK_EN
    assign out_of_range = |addr[31:AW];
`else
    assign out_of_range = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        size_d     = size_q;
        sign_ext_d = sign_ext_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        fault_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    is_store_d = is_store;
                    size_d     = size;
                    sign_ext_d = sign_ext;
                    addr_d     = addr[AW-1:0];
                    wdata_d    = wdata;
                    if (misaligned || out_of_range) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                    end else if (is_store && size[1])
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                if (is_store_q) begin
                    merge_d = mem_rdata;
                    state_d = WR;
                end else begin
                    rdata_d = extract(mem_rdata, size_q, addr_q[1:0], sign_ext_q);
                    state_d = DONE;
                end
            end
            WR:      state_d = DONE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered against the state being entered.
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        mem_read_d  = (state_d == RD);
        mem_write_d = (state_d == WR);
        mem_addr_d  = (state_d == RD || state_d == WR) ? 32'(addr_d[AW-1:2]) : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            size_q      <= 2'b00;
            sign_ext_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            merge_q     <= 32'h0;
            rdata_q     <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            size_q      <= size_d;
            sign_ext_q  <= sign_ext_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // Word stores bypass RD, so merge() ignores merge_q for full-word size.
    assign mem_wdata = mem_write_q ? merge(merge_q, wdata_q, size_q, addr_q[1:0]) : 32'h0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a 64-word behavioural data memory.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, fault, mem_write, mem_read;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:63];
    int checks = 0;
    int errors = 0;

    int          lat, n_rd, n_wr, n_both, first_rd, first_wr;
    logic        got_fault, seen;
    logic [31:0] wr_addr, wr_data;

    lsu_ctrl #(.ADDR_WORDS_LOG2(6)) dut (
        .clk(clk), .rst(rst), .req(req), .is_store(is_store), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .fault(fault), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one access and follow it to its done cycle (sampled on negedges).
    task automatic access(input logic st, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req = 1'b1; is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
        lat = 0; n_rd = 0; n_wr = 0; n_both = 0; first_rd = 0; first_wr = 0;
        got_fault = 1'b0; seen = 1'b0; wr_addr = 32'hx; wr_data = 32'hx;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (mem_read) begin n_rd++; if (first_rd == 0) first_rd = lat; end
            if (mem_write) begin n_wr++; wr_addr = mem_addr; wr_data = mem_wdata; first_wr = lat; end
            if (mem_read && mem_write) n_both++;
            if (done) begin got_fault = fault; seen = 1'b1; break; end
        end
        check("done_within_budget", 32'(seen), 32'd1);
        check("no_rd_wr_overlap", 32'(n_both), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b1;

        // sw 0x8090A0B0 @0x10
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'h8090A0B0);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_nwr", 32'(n_wr), 32'd1);
        check("sw_nrd", 32'(n_rd), 32'd0);
        check("sw_waddr", wr_addr, 32'd4);
        check("sw_wdata", wr_data, 32'h8090A0B0);
        check("sw_fault", 32'(got_fault), 32'd0);

        access(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_nrd", 32'(n_rd), 32'd1);
        check("lw_rdata", rdata, 32'h8090A0B0);

        access(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        check("lb_lat", 32'(lat), 32'd2);
        check("lb_rdata", rdata, 32'hFFFFFF80);
        access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        check("lbu_lat", 32'(lat), 32'd2);
        check("lbu_rdata", rdata, 32'h00000090);
        access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        check("lh_lat", 32'(lat), 32'd2);
        check("lh_rdata", rdata, 32'hFFFFA0B0);
        access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        check("lhu_rdata", rdata, 32'h00008090);

        // sb 0x55 @0x13 with junk in the upper wdata bits
        access(1'b1, 2'b00, 1'b0, 32'h13, 32'hAAAAAA55);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_nrd", 32'(n_rd), 32'd1);
        check("sb_nwr", 32'(n_wr), 32'd1);
        check("sb_rd_first", 32'(first_rd < first_wr), 32'd1);
        check("sb_wdata", wr_data, 32'h8090A055);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_after_sb", rdata, 32'h8090A055);

        access(1'b1, 2'b01, 1'b0, 32'h10, 32'hBBBB1234);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_waddr", wr_addr, 32'd4);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_after_sh", rdata, 32'h1234A055);

        // Misaligned accesses
        access(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        check("mis_lw_lat", 32'(lat), 32'd1);
        check("mis_lw_fault", 32'(got_fault), 32'd1);
        check("mis_lw_traffic", 32'(n_rd + n_wr), 32'd0);
        check("mis_lw_rdata", rdata, 32'h1234A055);
        access(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000FFFF);
        check("mis_sh_lat", 32'(lat), 32'd1);
        check("mis_sh_fault", 32'(got_fault), 32'd1);
        check("mis_sh_traffic", 32'(n_rd + n_wr), 32'd0);
        check("mis_sh_mem", mem[4], 32'h1234A055);
        check("mis_sh_rdata", rdata, 32'h1234A055);

        // Address 0x100 wraps or faults depending on build
        access(1'b1, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF);
        access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
        check("oob_fault", 32'(got_fault), 32'd1);
        check("oob_lat", 32'(lat), 32'd1);
        check("oob_traffic", 32'(n_rd + n_wr), 32'd0);
`else
        check("wrap_fault", 32'(got_fault), 32'd0);
        check("wrap_rdata", rdata, 32'hDEADBEEF);
`endif

        // Reset during RD of sb 0x77 @0x10
        @(negedge clk);
        req = 1'b1; is_store = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h77;
        @(posedge clk);
        #1 req = 1'b0;
        check("rr_in_rd_read", 32'(mem_read), 32'd1);
        check("rr_in_rd_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_mem_read", 32'(mem_read), 32'd0);
        check("rr_mem_write", 32'(mem_write), 32'd0);
        check("rr_mem_addr", mem_addr, 32'h0);
        check("rr_rdata", rdata, 32'h0);
        check("rr_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("rr_mem_word4", mem[4], 32'h1234A055);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("rr_lw_lat", 32'(lat), 32'd2);
        check("rr_lw_rdata", rdata, 32'h1234A055);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
